// File: rtl/seq_shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier, one partial product per cycle.
// Optional macro EARLY_TERM_EN: stop RUN once the remaining multiplier is zero.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   OUT
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t          r_state;
  state_t          w_state_n;

  logic [PW-1:0]    r_mcand;
  logic [WIDTH-1:0] r_mplier;
  logic [PW-1:0]    r_acc;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_out;

  logic [PW-1:0]    w_pp;
  logic [PW-1:0]    w_acc_n;
  logic             w_last;
  logic             w_load;
  logic             w_step;
  logic             w_finish;

  // Single time-shared partial-product row; adder carry-out is dropped.
  assign w_pp    = r_mcand & {PW{r_mplier[0]}};
  assign w_acc_n = r_acc + w_pp;

`ifdef EARLY_TERM_EN
  assign w_last = (r_cnt == CNT_LAST) ||
                  (r_mplier[WIDTH-1:1] == '0);
`else
  assign w_last = (r_cnt == CNT_LAST);
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_n;
    end
  end

  // Next-state and datapath control strobes.
  always_comb begin
    w_state_n = r_state;
    w_load    = 1'b0;
    w_step    = 1'b0;
    w_finish  = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load    = 1'b1;
          w_state_n = S_RUN;
        end
      end
      S_RUN: begin
        w_step = 1'b1;
        if (w_last) begin
          w_finish  = 1'b1;
          w_state_n = S_DONE;
        end
      end
      S_DONE: begin
        if (start) begin
          w_load    = 1'b1;
          w_state_n = S_RUN;
        end else begin
          w_state_n = S_IDLE;
        end
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase
  end

  // Operand capture on accept, then one shift-add step per RUN cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_mcand  <= '0;
      r_mplier <= '0;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_load) begin
      r_mcand  <= {{WIDTH{1'b0}}, A};
      r_mplier <= B;
      r_acc    <= '0;
      r_cnt    <= '0;
    end else if (w_step) begin
      r_acc    <= w_acc_n;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + 1'b1;
    end
  end

  // Product register: written only on the finishing step.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out <= '0;
    end else if (w_finish) begin
      r_out <= w_acc_n;
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign OUT  = r_out;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Scoreboard bench for seq_shift_add_multiplier.
// Expected products and done cycles are queued at issue, checked on done.
module tb_seq_shift_add_multiplier;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [W-1:0]  A;
  logic [W-1:0]  B;
  logic          busy;
  logic          done;
  logic [2*W-1:0] OUT;

  int unsigned cyc = 0;
  int compared = 0;
  int mismatched = 0;

  typedef struct {
    logic [2*W-1:0] p;
    int unsigned    c;
  } exp_t;

  exp_t q[$];

  seq_shift_add_multiplier #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .A     (A),
    .B     (B),
    .busy  (busy),
    .done  (done),
    .OUT   (OUT)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h (cycle %0d)",
               n, act, exp, cyc);
    end
  endtask

  function automatic int unsigned lat(input logic [W-1:0] b);
`ifdef EARLY_TERM_EN
    int unsigned m;
    m = 1;
    for (int i = 0; i < W; i++)
      if (b[i]) m = i + 1;
    return m;
`else
    return W;
`endif
  endfunction

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    exp_t x;
    if (!reset && done) begin
      if (q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL spurious_done: got OUT=%h expected no done (cycle %0d)",
                 OUT, cyc);
      end else begin
        x = q.pop_front();
        chk("product", OUT, x.p);
        chk("done_cycle", 64'(cyc), 64'(x.c));
        chk("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  // Issue one operation at the current negedge; returns at the
  // negedge where done is expected. keep leaves start high.
  task automatic issue(input logic [W-1:0] a,
                       input logic [W-1:0] b,
                       input bit keep);
    int unsigned l;
    exp_t x;
    start = 1'b1;
    A = a;
    B = b;
    l = lat(b);
    x.p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    x.c = cyc + 1 + l;
    q.push_back(x);
    @(negedge clk);
    chk("busy_run", 64'(busy), 64'd1);
    if (!keep) start = 1'b0;
    for (int i = 0; i < int'(l); i++) begin
      A = $urandom;
      B = $urandom;
      @(negedge clk);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish by 1ms");
    $fatal(1);
  end

  initial begin
    int unsigned n;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    reset = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    repeat (3) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_out", OUT, 64'd0);
    reset = 1'b0;
    @(negedge clk);

    issue(32'd3, 32'd5, 1'b0);
    repeat (2) @(negedge clk);
    issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    @(negedge clk);
    issue(32'h1234, 32'd0, 1'b0);
    @(negedge clk);
    issue(32'd5, 32'h100, 1'b0);
    repeat (2) @(negedge clk);

    // Abort a run with reset before it can finish.
    start = 1'b1;
    A = 32'd7;
    B = 32'd9;
    @(negedge clk);
    start = 1'b0;
    n = (lat(32'd9) < 10) ? lat(32'd9) - 2 : 9;
    repeat (n) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    chk("abort_out", OUT, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    issue(32'd2, 32'd2, 1'b0);
    @(negedge clk);

    // Start held high: back-to-back re-entry from DONE.
    issue(32'd4, 32'd6, 1'b1);
    issue($urandom, $urandom, 1'b1);
    issue(32'd4, 32'd6, 1'b0);
    @(negedge clk);

    for (int k = 0; k < 40; k++) begin
      ra = $urandom;
      rb = $urandom >> $urandom_range(0, W - 1);
      if ($urandom_range(0, 7) == 0) rb = '0;
      issue(ra, rb, 1'($urandom_range(0, 1)));
      start = 1'b0;
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             compared, mismatched);
    $finish;
  end

endmodule
